// File: rtl/serial_frame_tx_arbiter.sv
// Two-requester round-robin arbiter that serialises the granted request as
// start bit, port (MSB first), length (MSB first), L data bits and a stop bit.
module serial_frame_tx_arbiter #(
  parameter int PORT_W = 2,
  parameter int LEN_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clkEn,
  input  logic                    req0,
  input  logic [PORT_W-1:0]       port0,
  input  logic [LEN_W-1:0]        len0,
  input  logic [(2**LEN_W)-2:0]   data0,
  input  logic                    req1,
  input  logic [PORT_W-1:0]       port1,
  input  logic [LEN_W-1:0]        len1,
  input  logic [(2**LEN_W)-2:0]   data1,
  output logic                    ack0,
  output logic                    ack1,
  output logic                    grant_id,
  output logic                    SerOut,
  output logic                    busy,
  output logic                    done
);

  localparam int DATA_W = 2**LEN_W - 1;

  typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA, STOP} state_t;

  state_t              state;
  logic [PORT_W-1:0]   port_sh;
  logic [LEN_W-1:0]    len_reg;
  logic [LEN_W-1:0]    len_sh;
  logic [LEN_W-1:0]    cnt;
  logic [DATA_W-1:0]   data_reg;
  logic                rr_ptr;
  logic                pick;

  // With both requesting, rr_ptr decides; otherwise the lone requester wins.
  assign pick = (req0 && req1) ? rr_ptr : req1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      SerOut   <= 1'b1;
      busy     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      done     <= 1'b0;
      grant_id <= 1'b0;
      rr_ptr   <= 1'b0;
      port_sh  <= '0;
      len_reg  <= '0;
      len_sh   <= '0;
      cnt      <= '0;
      data_reg <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      if (clkEn) begin
        unique case (state)
          IDLE: begin
            if (req0 || req1) begin
              grant_id <= pick;
              rr_ptr   <= ~pick;
              ack0     <= ~pick;
              ack1     <= pick;
              port_sh  <= pick ? port1 : port0;
              len_reg  <= pick ? len1  : len0;
              len_sh   <= pick ? len1  : len0;
              data_reg <= pick ? data1 : data0;
              busy     <= 1'b1;
              SerOut   <= 1'b0;
              state    <= START;
            end
          end
          START: begin
            SerOut  <= port_sh[PORT_W-1];
            port_sh <= port_sh << 1;
            cnt     <= '0;
            state   <= PORT;
          end
          PORT: begin
            if (cnt == LEN_W'(PORT_W - 1)) begin
              SerOut <= len_sh[LEN_W-1];
              len_sh <= len_sh << 1;
              cnt    <= '0;
              state  <= LEN;
            end else begin
              SerOut  <= port_sh[PORT_W-1];
              port_sh <= port_sh << 1;
              cnt     <= cnt + 1'b1;
            end
          end
          LEN: begin
            if (cnt == LEN_W'(LEN_W - 1)) begin
              // DATA reuses cnt as a down-counting bit index from L-1 to 0.
              if (len_reg != '0) begin
                SerOut <= data_reg[len_reg - 1'b1];
                cnt    <= len_reg - 1'b1;
                state  <= DATA;
              end else begin
                SerOut <= 1'b1;
                state  <= STOP;
              end
            end else begin
              SerOut <= len_sh[LEN_W-1];
              len_sh <= len_sh << 1;
              cnt    <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == '0) begin
              SerOut <= 1'b1;
              state  <= STOP;
            end else begin
              SerOut <= data_reg[cnt - 1'b1];
              cnt    <= cnt - 1'b1;
            end
          end
          STOP: begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_tx_arbiter.sv
// Randomised bench comparing the transmitter against a bit-queue reference
// model that builds each frame from its fields and replays one bit per tick.
module tb_serial_frame_tx_arbiter;

  localparam int PORT_W = 2;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clkEn = 1'b0;
  logic [1:0] req = 2'b00;
  logic [PORT_W-1:0] port_a [2];
  logic [LEN_W-1:0]  len_a  [2];
  logic [DATA_W-1:0] data_a [2];
  logic ack0, ack1, grant_id, SerOut, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int mode = 0;

  // Reference model state: the frame bits still to send after the current one.
  bit m_ser = 1'b1;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_gid = 1'b0;
  bit m_rr = 1'b0;
  bit m_active = 1'b0;
  bit m_ack [2];
  bit m_q [$];

  serial_frame_tx_arbiter #(.PORT_W(PORT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn),
    .req0(req[0]), .port0(port_a[0]), .len0(len_a[0]), .data0(data_a[0]),
    .req1(req[1]), .port1(port_a[1]), .len1(len_a[1]), .data1(data_a[1]),
    .ack0(ack0), .ack1(ack1), .grant_id(grant_id),
    .SerOut(SerOut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    int g;
    logic [LEN_W-1:0] l;
    m_ack[0] = 1'b0;
    m_ack[1] = 1'b0;
    m_done   = 1'b0;
    if (rst) begin
      m_ser = 1'b1; m_busy = 1'b0; m_gid = 1'b0; m_rr = 1'b0; m_active = 1'b0;
      m_q.delete();
    end else if (clkEn) begin
      if (m_active) begin
        if (m_q.size() > 0) m_ser = m_q.pop_front();
        else begin
          m_active = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_ser = 1'b1;
        end
      end else if (req[0] || req[1]) begin
        g = (req[0] && req[1]) ? int'(m_rr) : (req[1] ? 1 : 0);
        m_rr = (g == 0);
        m_gid = (g == 1);
        m_ack[g] = 1'b1;
        m_busy = 1'b1;
        m_active = 1'b1;
        m_ser = 1'b0;
        l = len_a[g];
        m_q.delete();
        for (int b = PORT_W - 1; b >= 0; b--) m_q.push_back(port_a[g][b]);
        for (int b = LEN_W - 1; b >= 0; b--) m_q.push_back(l[b]);
        for (int b = int'(l) - 1; b >= 0; b--) m_q.push_back(data_a[g][b]);
        m_q.push_back(1'b1);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("SerOut", SerOut, m_ser);
    checkOutput("busy", busy, m_busy);
    checkOutput("done", done, m_done);
    checkOutput("ack0", ack0, m_ack[0]);
    checkOutput("ack1", ack1, m_ack[1]);
    if (m_busy) checkOutput("grant_id", grant_id, m_gid);
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
    case (mode)
      0:       clkEn = 1'b1;
      1:       clkEn = (cyc % 4 == 0);
      default: clkEn = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic randomize_fields(input int i);
    int r;
    r = $urandom_range(0, 3);
    port_a[i] = PORT_W'($urandom);
    len_a[i]  = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : LEN_W'($urandom);
    data_a[i] = DATA_W'($urandom);
  endtask

  task automatic applyStimulus(input int cycles, input bit auto_req);
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (auto_req) begin
        for (int i = 0; i < 2; i++) begin
          if (req[i] && m_ack[i]) begin
            req[i] = 1'b0;
            randomize_fields(i);
          end else if (!req[i] && $urandom_range(0, 3) == 0) begin
            randomize_fields(i);
            req[i] = 1'b1;
          end else if (req[i] && $urandom_range(0, 59) == 0) begin
            req[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic wait_ack(input int i);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      if (m_ack[i]) seen = 1'b1;
    end
    checkOutput("ack_seen", 32'(seen), 32'd1);
    req[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      port_a[i] = '0; len_a[i] = '0; data_a[i] = '0;
    end
    mode = 0;
    applyStimulus(3, 1'b0);
    rst = 1'b0;
    applyStimulus(2, 1'b0);

    // Basic frame; fields change right after the grant and must not leak in.
    port_a[0] = 2'b10; len_a[0] = 4'd3; data_a[0] = 15'h7FF5; req[0] = 1'b1;
    wait_ack(0);
    data_a[0] = 15'h0000; len_a[0] = 4'd15; port_a[0] = 2'b01;
    applyStimulus(20, 1'b0);

    port_a[1] = 2'b01; len_a[1] = 4'd0; data_a[1] = 15'h7FFF; req[1] = 1'b1;
    wait_ack(1);
    applyStimulus(15, 1'b0);

    // Both held: grants must alternate with an idle bit between frames.
    len_a[0] = 4'd2; len_a[1] = 4'd2; data_a[0] = 15'h0002; data_a[1] = 15'h0001;
    req = 2'b11;
    applyStimulus(50, 1'b0);
    req = 2'b00;
    applyStimulus(15, 1'b0);

    mode = 1;
    port_a[0] = 2'b11; len_a[0] = 4'd1; data_a[0] = 15'h0001; req[0] = 1'b1;
    wait_ack(0);
    applyStimulus(50, 1'b0);

    // Reset in the middle of the data field, then contend with the pointer cleared.
    mode = 0;
    port_a[0] = 2'b00; len_a[0] = 4'd15; data_a[0] = 15'h7FFF; req[0] = 1'b1;
    wait_ack(0);
    for (int n = 0; n < 100; n++) begin
      tick();
      if (m_active && m_q.size() == 8) break;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    len_a[0] = 4'd2; len_a[1] = 4'd1;
    req = 2'b11;
    applyStimulus(40, 1'b0);
    req = 2'b00;
    applyStimulus(25, 1'b0);

    mode = 2;
    applyStimulus(3000, 1'b1);
    req = 2'b00;
    mode = 0;
    applyStimulus(40, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx_arbiter.md
Name: serial_frame_tx_arbiter

Overview:
Transmit-side companion to the Lab 2 serial port-router receiver. It arbitrates between two parallel requesters and serialises the granted request onto SerOut using the receiver's frame format: start bit, port number, data length, data bits. Bit timing comes from the shared clkEn tick, and SerOut drives the receiver's SerIn directly. The block sequences its own shift and count datapath: a bit counter, shift register and length register.

Parameters:
- PORT_W, 2: width of the port-number field.
- LEN_W, 4: width of the length field. DATA_W = 2**LEN_W - 1 (15) is a derived localparam.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- clkEn  in  1  bit-rate tick. The FSM and SerOut change only on clk edges where clkEn=1.
- req0  in  1  requester 0 frame request, level. Held until ack0.
- port0  in  PORT_W  requester 0 destination port.
- len0  in  LEN_W  requester 0 data bit count L, 0..DATA_W.
- data0  in  DATA_W  requester 0 payload; only bits [L-1:0] are used.
- req1, port1, len1, data1  in  same as requester 0, for requester 1.
- ack0, ack1  out  1  one-clk grant pulse; fields are sampled on this edge.
- grant_id  out  1  requester being served, valid while busy.
- SerOut  out  1  serial line, idle high.
- busy  out  1  high from grant through the stop bit.
- done  out  1  one-clk pulse at end of stop bit.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, applied on a clk edge with rst=1, and has priority over clkEn and requests.
- Reset values: state=IDLE, SerOut=1, busy=0, ack0=ack1=0, done=0, grant_id=0, rr_ptr=0 (requester 0 favoured). Reset mid-frame aborts the frame: SerOut=1 on the next cycle, no done pulse, and the aborted requester gets no second ack.
- States: IDLE, START, PORT, LEN, DATA, STOP. All transitions happen only on edges with clkEn=1. When clkEn=0 every register holds, except that ack and done clear after one cycle.
- IDLE: SerOut=1. On clkEn with any req, grant as follows:
  - Only one req: grant it.
  - Both req: grant the one selected by rr_ptr.
  - On grant: latch port, len and data into internal registers; pulse ack for exactly that one clk; set grant_id and busy=1; SerOut<=0; go to START.
  - rr_ptr <= ~granted_id.
  - No req: stay in IDLE.
- START: one bit time of 0. Next clkEn: go to PORT, SerOut<=port[PORT_W-1], bit counter=0.
- PORT: port bits are sent MSB first, one per clkEn. After PORT_W bits, go to LEN with SerOut<=len[LEN_W-1].
- LEN: length bits are sent MSB first. After LEN_W bits:
  - If L>0: go to DATA with SerOut<=data[L-1].
  - If L=0: go to STOP with SerOut<=1.
- DATA: data bits are sent data[L-1] down to data[0], exactly L bit times, tracked by a down-counter. After the last bit: go to STOP, SerOut<=1.
- STOP: one bit time of 1. Next clkEn: go to IDLE, busy<=0, done pulse for one clk.
  - A grant is never issued on the same clkEn that leaves STOP. This guarantees at least one extra idle-high bit between frames.
- Frame length: 1 + PORT_W + LEN_W + L + 1 bit times. Each bit lasts exactly from one clkEn edge to the next.
- Input stability:
  - Inputs are sampled only at the grant edge. Later changes to the port, len or data fields, or deassertion of req, have no effect on the frame in flight.
  - A req that drops before it is granted is never served.
- Port and len fields are sent verbatim; no range checking is needed because len is at most DATA_W by construction.

Test Plan:
- Basic frame: rst, then req0 with port0=2'b10, len0=4'd3, data0=...101, clkEn every cycle.
  - ack0 pulses once.
  - SerOut per bit = 0,1,0,0,0,1,1,1,0,1,1 (11 bits).
  - done pulses at the edge ending the stop bit; busy is high throughout the frame.
- Zero length: req1 with port1=2'b01, len1=0.
  - SerOut = 0,0,1,0,0,0,0,1 (8 bits), no DATA state.
  - grant_id=1, ack1 only.
- Round robin: req0 and req1 both held high after reset, each with len=2.
  - Grant order is 0,1,0,1.
  - At least one idle-high bit between frames.
  - Each ack is exactly 1 clk wide.
- Slow tick: clkEn high 1 cycle in 4, len0=1, data0[0]=1.
  - Each SerOut bit is held exactly 4 clks.
  - No state change on clkEn=0 cycles.
- Reset mid-DATA: req0 len0=15, data0=15'h7FFF; assert rst for 1 clk during DATA.
  - The next cycle shows SerOut=1, busy=0, and no done pulse.
  - With req1 and req0 both then held, req0 is granted first.
- Input change after ack: change data0 and len0 on the cycle after ack0.
  - The transmitted bits match the values at the grant edge.
